// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL supervisor / reset sequencer: state encodings,
// counter sizing helper and default timing for a 25 MHz reference clock.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } seq_state_e;

    // One extra bit over $clog2 so the terminal value always fits.
    function automatic int cnt_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

    localparam int DEF_NUM_CH              = 4;
    localparam int DEF_SYNC_STAGES         = 2;
    localparam int DEF_PLL_RST_CYCLES      = 32;     // 1.28 us at 25 MHz
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;  // ~2.6 ms at 25 MHz
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;   // ~41 us at 25 MHz
    localparam int DEF_STAGGER_CYCLES      = 16;
    localparam int DEF_CNT_W               = 8;

endpackage

// File: rtl/bit_sync.sv
// N-stage single-bit synchroniser for an input asynchronous to clk.
// All stages clear to 0 on the asynchronous active-high reset.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    // NOTE: sequential state always uses non-blocking assignments so every
    // stage samples the previous stage's old value on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: pulses the PLL reset, qualifies LOCK, then releases the
// per-domain resets in ascending, staggered order; recovers from lock loss.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_CH              = DEF_NUM_CH,
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int STAGGER_CYCLES      = DEF_STAGGER_CYCLES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic              in_clk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              soft_rst_req,
    output logic              pll_rst,
    output logic [NUM_CH-1:0] ch_rst,
    output logic              all_ready,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  lock_loss_cnt,
    output logic              timeout_err
);

    localparam int REL_CYCLES = NUM_CH * STAGGER_CYCLES;
    localparam int DWELL_MAX  =
        (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES)
            ? ((PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES)
            : ((LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES);
    localparam int DW = cnt_width(DWELL_MAX);
    localparam int SW = cnt_width(REL_CYCLES);

    localparam logic [DW-1:0] RST_LAST     = DW'(PLL_RST_CYCLES - 1);
    localparam logic [DW-1:0] TIMEOUT_LAST = DW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] STABLE_LAST  = DW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [SW-1:0] REL_LAST     = SW'(REL_CYCLES - 1);

    seq_state_e        cur;
    seq_state_e        nxt;
    logic [DW-1:0]     dwell;
    logic [DW-1:0]     dwell_n;
    logic [SW-1:0]     stag;
    logic [SW-1:0]     stag_n;
    logic              restart;
    logic              restart_n;
    logic              lost;
    logic              timed_out;
    logic              lock_s;
    logic [NUM_CH-1:0] ch_rst_n;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (in_clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // The dwell counter serves PLL_RESET, WAIT_LOCK and STABLE; it is held at
    // zero elsewhere so every state entry starts counting from 0.
    // NOTE: every combinational output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        nxt       = cur;
        dwell_n   = dwell + 1'b1;
        stag_n    = '0;
        restart_n = 1'b0;
        lost      = 1'b0;
        timed_out = 1'b0;

        case (cur)
            PLL_RESET: begin
                if (dwell == RST_LAST) begin
                    nxt     = WAIT_LOCK;
                    dwell_n = '0;
                end
            end

            WAIT_LOCK: begin
                if (lock_s) begin
                    nxt     = STABLE;
                    dwell_n = '0;
                end else if (dwell == TIMEOUT_LAST) begin
                    nxt       = PLL_RESET;
                    dwell_n   = '0;
                    timed_out = 1'b1;
                end
            end

            STABLE: begin
                if (!lock_s) begin
                    nxt     = WAIT_LOCK;
                    dwell_n = '0;
                end else if (dwell == STABLE_LAST) begin
                    nxt     = RELEASE;
                    dwell_n = '0;
                end
            end

            RELEASE: begin
                dwell_n = '0;
                if (!lock_s) begin
                    nxt  = PLL_RESET;
                    lost = 1'b1;
                end else if (soft_rst_req) begin
                    restart_n = 1'b1;
                end else if (restart) begin
                    // Hold cycle after a soft request: all channels stay in
                    // reset and the stagger starts again on the next edge.
                    stag_n = '0;
                end else if (stag == REL_LAST) begin
                    nxt = RUN;
                end else begin
                    stag_n = stag + 1'b1;
                end
            end

            RUN: begin
                dwell_n = '0;
                if (!lock_s) begin
                    nxt  = PLL_RESET;
                    lost = 1'b1;
                end else if (soft_rst_req) begin
                    nxt       = RELEASE;
                    restart_n = 1'b1;
                end
            end

            default: begin
                nxt     = PLL_RESET;
                dwell_n = '0;
            end
        endcase
    end

    // Channel k drops once the stagger count reaches k*STAGGER_CYCLES.
    always_comb begin
        ch_rst_n = '1;
        if (nxt == RUN) begin
            ch_rst_n = '0;
        end else if (nxt == RELEASE && !restart_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (stag_n >= SW'(k * STAGGER_CYCLES)) begin
                    ch_rst_n[k] = 1'b0;
                end
            end
        end
    end

    // Outputs are registered from next-state values so they change on the
    // same edge as the state they belong to.
    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            cur           <= PLL_RESET;
            dwell         <= '0;
            stag          <= '0;
            restart       <= 1'b0;
            pll_rst       <= 1'b1;
            ch_rst        <= '1;
            all_ready     <= 1'b0;
            lock_loss_cnt <= '0;
            timeout_err   <= 1'b0;
        end else begin
            cur       <= nxt;
            dwell     <= dwell_n;
            stag      <= stag_n;
            restart   <= restart_n;
            pll_rst   <= (nxt == PLL_RESET);
            ch_rst    <= ch_rst_n;
            all_ready <= (nxt == RUN);
            if (lost && lock_loss_cnt != '1) begin
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign state = cur;

endmodule
